// File: rtl/tmon_pkg.sv
// Shared types and constants for the traffic-light monitor (tlight_mon).
// Lamp decode, fault codes and the sequencing rules both ways obey.
package tmon_pkg;

  typedef enum logic [1:0] {
    RED     = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    INVALID = 2'd3
  } lamp_t;

  typedef enum logic [2:0] {
    F_NONE     = 3'd0,
    F_LAMP     = 3'd1,
    F_CONFLICT = 3'd2,
    F_SEQ      = 3'd3,
    F_HEX      = 3'd4,
    F_TIMEOUT  = 3'd5
  } fault_t;

  localparam logic [3:0] GREEN_HEX   = 4'd9;
  localparam logic [3:0] YEL_START   = 4'd3;
  localparam logic [2:0] YEL_MAX_SEC = 3'd4;

  // Exactly one lamp lit gives a colour; anything else is INVALID.
  function automatic lamp_t decode_lamp(input logic r, input logic g, input logic y);
    lamp_t l;
    case ({r, g, y})
      3'b100:  l = RED;
      3'b010:  l = GREEN;
      3'b001:  l = YELLOW;
      default: l = INVALID;
    endcase
    return l;
  endfunction

  function automatic logic legal_step(input lamp_t prev, input lamp_t cur);
    return (prev == cur) ||
           (prev == GREEN  && cur == YELLOW) ||
           (prev == YELLOW && cur == RED)    ||
           (prev == RED    && cur == GREEN);
  endfunction

endpackage

// File: rtl/tmon_way.sv
// Per-way lamp decode, history and SEQ/HEX/TIMEOUT detection (combinational flags).
// HEX and TIMEOUT logic exists only when TMON_HEX_CHK_EN is defined.
module tmon_way
  import tmon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_armed,
  input  logic       i_sec,
  input  logic       i_r,
  input  logic       i_g,
  input  logic       i_y,
  input  logic [3:0] i_hex,
  output lamp_t      o_lamp,
  output logic       o_lamp_err,
  output logic       o_seq_err,
  output logic       o_hex_err,
  output logic       o_tmo_err,
  output logic       o_red_to_green
);

  lamp_t w_lamp;
  lamp_t r_prev_lamp;

  assign w_lamp = decode_lamp(i_r, i_g, i_y);
  assign o_lamp = w_lamp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev_lamp <= RED;
    else     r_prev_lamp <= w_lamp;
  end

  assign o_lamp_err     = (w_lamp == INVALID);
  assign o_seq_err      = i_armed && !legal_step(r_prev_lamp, w_lamp);
  assign o_red_to_green = i_armed && (r_prev_lamp == RED) && (w_lamp == GREEN);

`ifdef TMON_HEX_CHK_EN
  logic [3:0] r_prev_hex;
  logic       r_prev_sec;
  logic [2:0] r_ysec;
  logic [3:0] w_hex_exp;

  // Tick counter saturates one past the limit so TIMEOUT fires once per interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_hex <= 4'd0;
      r_prev_sec <= 1'b0;
      r_ysec     <= 3'd0;
    end else begin
      r_prev_hex <= i_hex;
      r_prev_sec <= i_sec;
      if (w_lamp != YELLOW)                    r_ysec <= 3'd0;
      else if (i_sec && r_ysec <= YEL_MAX_SEC) r_ysec <= r_ysec + 3'd1;
    end
  end

  assign w_hex_exp = r_prev_sec ? (r_prev_hex - 4'd1) : r_prev_hex;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o_hex_err = 1'b0;
    if (w_lamp == GREEN && i_hex != GREEN_HEX) o_hex_err = 1'b1;
    if (i_armed) begin
      if (w_lamp == YELLOW && r_prev_lamp != YELLOW && i_hex != YEL_START) o_hex_err = 1'b1;
      if (w_lamp == YELLOW && r_prev_lamp == YELLOW && i_hex != w_hex_exp) o_hex_err = 1'b1;
      if (w_lamp == RED && r_prev_lamp == YELLOW && r_prev_hex != 4'd0)    o_hex_err = 1'b1;
    end
  end

  assign o_tmo_err = (w_lamp == YELLOW) && i_sec && (r_ysec == YEL_MAX_SEC);
`else
  logic w_unused_hex;
  assign w_unused_hex = ^{i_sec, i_hex};
  assign o_hex_err    = 1'b0;
  assign o_tmo_err    = 1'b0;
`endif

endmodule

// File: rtl/tlight_mon.sv
// Traffic-light monitor top: two way checkers, CONFLICT, fault priority/latching, counters.
// Optional HEX/TIMEOUT checks are enabled by defining TMON_HEX_CHK_EN.
module tlight_mon
  import tmon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sec,
  input  logic       rled0,
  input  logic       gled0,
  input  logic       yled0,
  input  logic [3:0] hex0n,
  input  logic       rled1,
  input  logic       gled1,
  input  logic       yled1,
  input  logic [3:0] hex1n,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_way,
  output logic [3:0] fault_cnt,
  output logic [7:0] cycle_cnt
);

  logic   r_armed;
  logic   r_fault;
  fault_t r_code;
  logic   r_way;
  logic [3:0] r_fault_cnt;
  logic [7:0] r_cycle_cnt;

  lamp_t  w_lamp0, w_lamp1;
  logic   w_lamp_err0, w_lamp_err1, w_seq_err0, w_seq_err1;
  logic   w_hex_err0, w_hex_err1, w_tmo_err0, w_tmo_err1;
  logic   w_r2g0, w_unused_r2g1;
  logic   w_conflict;
  fault_t w_code;
  logic   w_way;
  logic   w_any;

  tmon_way u_way0 (
    .clk(clk), .rst(rst), .i_armed(r_armed), .i_sec(sec),
    .i_r(rled0), .i_g(gled0), .i_y(yled0), .i_hex(hex0n),
    .o_lamp(w_lamp0), .o_lamp_err(w_lamp_err0), .o_seq_err(w_seq_err0),
    .o_hex_err(w_hex_err0), .o_tmo_err(w_tmo_err0), .o_red_to_green(w_r2g0)
  );

  tmon_way u_way1 (
    .clk(clk), .rst(rst), .i_armed(r_armed), .i_sec(sec),
    .i_r(rled1), .i_g(gled1), .i_y(yled1), .i_hex(hex1n),
    .o_lamp(w_lamp1), .o_lamp_err(w_lamp_err1), .o_seq_err(w_seq_err1),
    .o_hex_err(w_hex_err1), .o_tmo_err(w_tmo_err1), .o_red_to_green(w_unused_r2g1)
  );

  // An INVALID way is already a LAMP fault; CONFLICT only judges clean decodes.
  assign w_conflict = (w_lamp0 != RED) && (w_lamp1 != RED) &&
                      (w_lamp0 != INVALID) && (w_lamp1 != INVALID);

  always_comb begin
    w_code = F_NONE;
    w_way  = 1'b0;
    if      (w_lamp_err0) begin w_code = F_LAMP;     w_way = 1'b0; end
    else if (w_lamp_err1) begin w_code = F_LAMP;     w_way = 1'b1; end
    else if (w_conflict)  begin w_code = F_CONFLICT; w_way = 1'b0; end
    else if (w_seq_err0)  begin w_code = F_SEQ;      w_way = 1'b0; end
    else if (w_seq_err1)  begin w_code = F_SEQ;      w_way = 1'b1; end
    else if (w_hex_err0)  begin w_code = F_HEX;      w_way = 1'b0; end
    else if (w_hex_err1)  begin w_code = F_HEX;      w_way = 1'b1; end
    else if (w_tmo_err0)  begin w_code = F_TIMEOUT;  w_way = 1'b0; end
    else if (w_tmo_err1)  begin w_code = F_TIMEOUT;  w_way = 1'b1; end
  end

  assign w_any = (w_code != F_NONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_fault     <= 1'b0;
      r_code      <= F_NONE;
      r_way       <= 1'b0;
      r_fault_cnt <= 4'd0;
      r_cycle_cnt <= 8'd0;
    end else begin
      r_armed <= 1'b1;
      // A clear still captures a fault detected in the same cycle.
      if (fault_clr) begin
        r_fault <= w_any;
        r_code  <= w_code;
        r_way   <= w_way;
      end else if (!r_fault && w_any) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
        r_way   <= w_way;
      end
      if (w_any && r_fault_cnt != 4'hF) r_fault_cnt <= r_fault_cnt + 4'd1;
      if (w_r2g0)                       r_cycle_cnt <= r_cycle_cnt + 8'd1;
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_code;
  assign fault_way  = r_way;
  assign fault_cnt  = r_fault_cnt;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_tlight_mon.sv
// Directed bench for tlight_mon; expectations follow TMON_HEX_CHK_EN when it is defined.
module tb_tlight_mon;

  logic       clk = 1'b0;
  logic       rst, sec, fault_clr;
  logic       rled0, gled0, yled0, rled1, gled1, yled1;
  logic [3:0] hex0n, hex1n;
  logic       fault, fault_way;
  logic [2:0] fault_code;
  logic [3:0] fault_cnt;
  logic [7:0] cycle_cnt;

  int errors = 0;
  int checks = 0;

`ifdef TMON_HEX_CHK_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif

  localparam logic [2:0] LR = 3'b100, LG = 3'b010, LY = 3'b001, LOFF = 3'b000;

  tlight_mon dut (
    .clk(clk), .rst(rst), .sec(sec),
    .rled0(rled0), .gled0(gled0), .yled0(yled0), .hex0n(hex0n),
    .rled1(rled1), .gled1(gled1), .yled1(yled1), .hex1n(hex1n),
    .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code),
    .fault_way(fault_way), .fault_cnt(fault_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; one step spans exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] l0, input logic [3:0] h0,
                       input logic [2:0] l1, input logic [3:0] h1, input logic s);
    {rled0, gled0, yled0} = l0;
    hex0n = h0;
    {rled1, gled1, yled1} = l1;
    hex1n = h1;
    sec = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fault_clr = 1'b0;
    drive(LR, 4'd0, LR, 4'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fault_clr = 1'b0;
    drive(LG, 4'd9, LG, 4'd9, 1'b1);
    step();
    checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL reset_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", fault_code); end
    checks++; if (fault_way !== 1'b0)  begin errors++; $display("FAIL reset_way: got %0b want 0", fault_way); end
    checks++; if (fault_cnt !== 4'd0)  begin errors++; $display("FAIL reset_fcnt: got %0d want 0", fault_cnt); end
    checks++; if (cycle_cnt !== 8'd0)  begin errors++; $display("FAIL reset_ccnt: got %0d want 0", cycle_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_legal_cycle();
    do_reset();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step(); step();
    drive(LY, 4'd3, LR, 4'd0, 1'b1); step();
    drive(LY, 4'd2, LR, 4'd0, 1'b1); step();
    drive(LY, 4'd1, LR, 4'd0, 1'b1); step();
    drive(LY, 4'd0, LR, 4'd0, 1'b0); step();
    drive(LR, 4'd0, LG, 4'd9, 1'b0); step(); step();
    drive(LR, 4'd0, LY, 4'd3, 1'b1); step();
    drive(LR, 4'd0, LY, 4'd2, 1'b1); step();
    drive(LR, 4'd0, LY, 4'd1, 1'b1); step();
    drive(LR, 4'd0, LY, 4'd0, 1'b0); step();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step();
    checks++; if (fault !== 1'b0)     begin errors++; $display("FAIL legal_fault: got %0b want 0 (code %0d)", fault, fault_code); end
    checks++; if (fault_cnt !== 4'd0) begin errors++; $display("FAIL legal_fcnt: got %0d want 0", fault_cnt); end
    checks++; if (cycle_cnt !== 8'd1) begin errors++; $display("FAIL legal_ccnt: got %0d want 1", cycle_cnt); end
  endtask

  // Continues from the legal cycle: way0 green, cycle_cnt already 1.
  task automatic test_reset_mid();
    drive(LG, 4'd9, LG, 4'd9, 1'b0); step();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mid_prefault: got %0b want 1", fault); end
    drive(LY, 4'd3, LR, 4'd0, 1'b0); step();
    #2 rst = 1'b1;
    #1;
    checks++; if (fault !== 1'b0)      begin errors++; $display("FAIL mid_rst_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL mid_rst_code: got %0d want 0", fault_code); end
    checks++; if (fault_way !== 1'b0)  begin errors++; $display("FAIL mid_rst_way: got %0b want 0", fault_way); end
    checks++; if (fault_cnt !== 4'd0)  begin errors++; $display("FAIL mid_rst_fcnt: got %0d want 0", fault_cnt); end
    checks++; if (cycle_cnt !== 8'd0)  begin errors++; $display("FAIL mid_rst_ccnt: got %0d want 0", cycle_cnt); end
    drive(LR, 4'd0, LG, 4'd9, 1'b0);
    step();
    rst = 1'b0;
    step();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_first_fault: got %0b want 0 (code %0d)", fault, fault_code); end
    step();
    checks++; if (fault !== 1'b0)     begin errors++; $display("FAIL mid_second_fault: got %0b want 0 (code %0d)", fault, fault_code); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("FAIL mid_ccnt: got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step();
    drive(LG, 4'd9, LG, 4'd9, 1'b0); step();
    checks++; if (fault !== 1'b1)      begin errors++; $display("FAIL conf_fault: got %0b want 1", fault); end
    checks++; if (fault_code !== 3'd2) begin errors++; $display("FAIL conf_code: got %0d want 2", fault_code); end
    checks++; if (fault_way !== 1'b0)  begin errors++; $display("FAIL conf_way: got %0b want 0", fault_way); end
    checks++; if (fault_cnt !== 4'd1)  begin errors++; $display("FAIL conf_fcnt: got %0d want 1", fault_cnt); end
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step();
    checks++; if (fault_code !== 3'd2) begin errors++; $display("FAIL conf_sticky_code: got %0d want 2", fault_code); end
    checks++; if (fault_cnt !== 4'd2)  begin errors++; $display("FAIL conf_fcnt2: got %0d want 2", fault_cnt); end
  endtask

  task automatic test_seq();
    do_reset();
    drive(LR, 4'd0, LG, 4'd9, 1'b0); step(); step();
    drive(LR, 4'd0, LR, 4'd0, 1'b0); step();
    checks++; if (fault !== 1'b1)      begin errors++; $display("FAIL seq_fault: got %0b want 1", fault); end
    checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL seq_code: got %0d want 3", fault_code); end
    checks++; if (fault_way !== 1'b1)  begin errors++; $display("FAIL seq_way: got %0b want 1", fault_way); end
  endtask

  task automatic test_hex_then_lamp();
    logic [2:0] exp_code;
    logic [3:0] exp_cnt;
    exp_code = HEX_EN ? 3'd4 : 3'd1;
    exp_cnt  = HEX_EN ? 4'd2 : 4'd1;
    do_reset();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step();
    drive(LY, 4'd3, LR, 4'd0, 1'b1); step();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL hl_entry_fault: got %0b want 0", fault); end
    drive(LY, 4'd1, LR, 4'd0, 1'b0); step();
    checks++; if (fault !== HEX_EN) begin errors++; $display("FAIL hl_skip_fault: got %0b want %0b", fault, HEX_EN); end
    drive(3'b101, 4'd1, LR, 4'd0, 1'b0); step();
    checks++; if (fault !== 1'b1)          begin errors++; $display("FAIL hl_fault: got %0b want 1", fault); end
    checks++; if (fault_code !== exp_code) begin errors++; $display("FAIL hl_code: got %0d want %0d", fault_code, exp_code); end
    checks++; if (fault_way !== 1'b0)      begin errors++; $display("FAIL hl_way: got %0b want 0", fault_way); end
    checks++; if (fault_cnt !== exp_cnt)   begin errors++; $display("FAIL hl_fcnt: got %0d want %0d", fault_cnt, exp_cnt); end
    drive(LR, 4'd0, LR, 4'd0, 1'b0); step();
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    checks++; if (fault !== 1'b0)              begin errors++; $display("FAIL hl_clr_fault: got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0)         begin errors++; $display("FAIL hl_clr_code: got %0d want 0", fault_code); end
    checks++; if (fault_cnt !== exp_cnt + 4'd1) begin errors++; $display("FAIL hl_clr_fcnt: got %0d want %0d", fault_cnt, exp_cnt + 4'd1); end
  endtask

  task automatic test_timeout();
    logic [2:0] exp_code;
    exp_code = HEX_EN ? 3'd5 : 3'd0;
    do_reset();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step();
    drive(LY, 4'd0, LR, 4'd0, 1'b0); step();
    for (int k = 1; k <= 5; k++) begin
      fault_clr = (k == 5);
      drive(LY, 4'd0, LR, 4'd0, 1'b1); step();
      fault_clr = 1'b0;
      drive(LY, 4'd0, LR, 4'd0, 1'b0); step();
    end
    checks++; if (fault !== HEX_EN)        begin errors++; $display("FAIL tmo_fault: got %0b want %0b", fault, HEX_EN); end
    checks++; if (fault_code !== exp_code) begin errors++; $display("FAIL tmo_code: got %0d want %0d", fault_code, exp_code); end
    checks++; if (fault_way !== 1'b0)      begin errors++; $display("FAIL tmo_way: got %0b want 0", fault_way); end
  endtask

  task automatic test_priority();
    do_reset();
    drive(LG, 4'd9, LR, 4'd0, 1'b0); step(); step();
    drive(LOFF, 4'd0, LOFF, 4'd0, 1'b0); step();
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL prio_code: got %0d want 1", fault_code); end
    checks++; if (fault_way !== 1'b0)  begin errors++; $display("FAIL prio_way: got %0b want 0", fault_way); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(LR, 4'd0, 3'b111, 4'd0, 1'b0);
    repeat (20) step();
    checks++; if (fault_cnt !== 4'd15) begin errors++; $display("FAIL sat_fcnt: got %0d want 15", fault_cnt); end
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL sat_code: got %0d want 1", fault_code); end
    checks++; if (fault_way !== 1'b1)  begin errors++; $display("FAIL sat_way: got %0b want 1", fault_way); end
    fault_clr = 1'b1; step(); fault_clr = 1'b0;
    checks++; if (fault !== 1'b1)      begin errors++; $display("FAIL sat_clr_fault: got %0b want 1", fault); end
    checks++; if (fault_cnt !== 4'd15) begin errors++; $display("FAIL sat_clr_fcnt: got %0d want 15", fault_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    fault_clr = 1'b0;
    drive(LR, 4'd0, LR, 4'd0, 1'b0);
    test_reset();
    test_legal_cycle();
    test_reset_mid();
    test_conflict();
    test_seq();
    test_hex_then_lamp();
    test_timeout();
    test_priority();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
